// File: rtl/latch_mem_wb_hs.sv
// MEM/WB pipeline register with valid/ready handshake, flush and sticky halt tracking.
// Define MEM_WB_SKID_EN for the two-entry skid buffer; otherwise a single entry is held.
module latch_mem_wb_hs #(
    parameter int NB_DATA       = 32,
    parameter int NB_ADDR       = 32,
    parameter int NB_REG        = 5,
    parameter int NB_WB_CTRL    = 3,
    parameter int NB_MEM_TO_REG = 2
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_enable_pipe,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NB_DATA-1:0]       i_mem_data,
    input  logic [NB_DATA-1:0]       i_alu_result,
    input  logic [NB_DATA-1:0]       i_data_inm,
    input  logic [NB_ADDR-1:0]       i_pc,
    input  logic [NB_WB_CTRL-1:0]    i_WB_control,
    input  logic [NB_REG-1:0]        i_write_register,
    input  logic                     i_halt_detected,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NB_DATA-1:0]       o_mem_data,
    output logic [NB_DATA-1:0]       o_alu_result,
    output logic [NB_DATA-1:0]       o_inm_ext,
    output logic [NB_ADDR-1:0]       o_pc,
    output logic [NB_MEM_TO_REG-1:0] o_mem_to_reg,
    output logic [NB_REG-1:0]        o_write_register,
    output logic                     o_reg_write,
    output logic                     o_halt_detected,
    output logic                     o_halted
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [NB_DATA-1:0]    mem_data;
        logic [NB_DATA-1:0]    alu_result;
        logic [NB_DATA-1:0]    data_inm;
        logic [NB_ADDR-1:0]    pc;
        logic [NB_WB_CTRL-1:0] wb_ctrl;
        logic [NB_REG-1:0]     write_register;
        logic                  halt;
    } entry_t;

    state_t state;
    entry_t head;
    entry_t in_entry;
    logic   push;
    logic   pop;

`ifdef MEM_WB_SKID_EN
    entry_t skid;
`endif

    assign in_entry = '{
        mem_data:       i_mem_data,
        alu_result:     i_alu_result,
        data_inm:       i_data_inm,
        pc:             i_pc,
        wb_ctrl:        i_WB_control,
        write_register: i_write_register,
        halt:           i_halt_detected
    };

    assign o_valid = (state != EMPTY);

`ifdef MEM_WB_SKID_EN
    // Skid entry absorbs one push while WB stalls, so o_ready never depends on i_ready.
    assign o_ready = i_enable_pipe & (state != TWO);
`else
    assign o_ready = i_enable_pipe & (~o_valid | i_ready);
`endif

    assign push = i_valid & o_ready;
    assign pop  = o_valid & i_ready & i_enable_pipe;

    // NOTE: every state and payload register uses <= so all of them update from
    // the same pre-edge values, regardless of statement order in this block.
    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            // NOTE: payload registers are cleared too, so data outputs read 0 after reset.
            state    <= EMPTY;
            head     <= '0;
            o_halted <= 1'b0;
`ifdef MEM_WB_SKID_EN
            skid     <= '0;
`endif
        end else if (i_flush) begin
            state <= EMPTY;
        end else begin
            if (pop && head.halt) begin
                o_halted <= 1'b1;
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= in_entry;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= in_entry;
                    end else if (pop) begin
                        state <= EMPTY;
`ifdef MEM_WB_SKID_EN
                    end else if (push) begin
                        skid  <= in_entry;
                        state <= TWO;
`endif
                    end
                end
`ifdef MEM_WB_SKID_EN
                TWO: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
`endif
                default: state <= EMPTY;
            endcase
        end
    end

    assign o_mem_data       = head.mem_data;
    assign o_alu_result     = head.alu_result;
    assign o_inm_ext        = head.data_inm;
    assign o_pc             = head.pc;
    assign o_mem_to_reg     = head.wb_ctrl[NB_MEM_TO_REG-1:0];
    assign o_write_register = head.write_register;
    // Register 0 is hardwired, so writes to it are dropped here rather than in the regfile.
    assign o_reg_write      = head.wb_ctrl[NB_WB_CTRL-1] & o_valid & (head.write_register != '0);
    assign o_halt_detected  = head.halt & o_valid;

endmodule

// File: tb/tb_latch_mem_wb_hs.sv
// Directed self-checking bench for latch_mem_wb_hs; expectations follow MEM_WB_SKID_EN
// when it is defined, and the single-entry behaviour otherwise.
module tb_latch_mem_wb_hs;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_enable_pipe;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_mem_data;
    logic [31:0] i_alu_result;
    logic [31:0] i_data_inm;
    logic [31:0] i_pc;
    logic [2:0]  i_WB_control;
    logic [4:0]  i_write_register;
    logic        i_halt_detected;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_mem_data;
    logic [31:0] o_alu_result;
    logic [31:0] o_inm_ext;
    logic [31:0] o_pc;
    logic [1:0]  o_mem_to_reg;
    logic [4:0]  o_write_register;
    logic        o_reg_write;
    logic        o_halt_detected;
    logic        o_halted;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

`ifdef MEM_WB_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    latch_mem_wb_hs dut (
        .i_clock          (clk),
        .i_reset          (i_reset),
        .i_enable_pipe    (i_enable_pipe),
        .i_flush          (i_flush),
        .i_valid          (i_valid),
        .o_ready          (o_ready),
        .i_mem_data       (i_mem_data),
        .i_alu_result     (i_alu_result),
        .i_data_inm       (i_data_inm),
        .i_pc             (i_pc),
        .i_WB_control     (i_WB_control),
        .i_write_register (i_write_register),
        .i_halt_detected  (i_halt_detected),
        .o_valid          (o_valid),
        .i_ready          (i_ready),
        .o_mem_data       (o_mem_data),
        .o_alu_result     (o_alu_result),
        .o_inm_ext        (o_inm_ext),
        .o_pc             (o_pc),
        .o_mem_to_reg     (o_mem_to_reg),
        .o_write_register (o_write_register),
        .o_reg_write      (o_reg_write),
        .o_halt_detected  (o_halt_detected),
        .o_halted         (o_halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Let the DUT take one negedge, then return half a cycle later for checks and new inputs.
    task automatic tick();
        @(negedge clk);
        @(posedge clk);
    endtask

    task automatic offer(input logic [31:0] alu, input logic [2:0] wbc, input logic [4:0] wreg, input logic halt);
        i_valid          = 1'b1;
        i_alu_result     = alu;
        i_mem_data       = alu ^ 32'hFFFF_0000;
        i_data_inm       = alu + 32'd1;
        i_pc             = {alu[29:0], 2'b00};
        i_WB_control     = wbc;
        i_write_register = wreg;
        i_halt_detected  = halt;
    endtask

    initial begin
        i_reset = 1'b1; i_enable_pipe = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_mem_data = '0; i_alu_result = '0; i_data_inm = '0; i_pc = '0;
        i_WB_control = '0; i_write_register = '0; i_halt_detected = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_alu", 64'(o_alu_result), 64'd0);
        check("rst_pc", 64'(o_pc), 64'd0);
        check("rst_halted", 64'(o_halted), 64'd0);
        i_reset = 1'b0;

        // Single push with WB consuming immediately.
        i_ready = 1'b1;
        offer(32'h1234_5678, 3'b100, 5'd5, 1'b0);
        tick();
        check("p1_valid", 64'(o_valid), 64'd1);
        check("p1_alu", 64'(o_alu_result), 64'h1234_5678);
        check("p1_mem", 64'(o_mem_data), 64'hEDCB_5678);
        check("p1_inm", 64'(o_inm_ext), 64'h1234_5679);
        check("p1_pc", 64'(o_pc), 64'h48D1_59E0);
        check("p1_regwr", 64'(o_reg_write), 64'd1);
        check("p1_m2r", 64'(o_mem_to_reg), 64'd0);
        check("p1_wreg", 64'(o_write_register), 64'd5);
        i_valid = 1'b0;
        tick();
        check("p1_drain", 64'(o_valid), 64'd0);
        check("p1_drain_rw", 64'(o_reg_write), 64'd0);

        // Back-to-back throughput with i_ready held high.
        for (int i = 0; i < 4; i++) begin
            offer(32'h100 + 32'(i), 3'b101, 5'd9, 1'b0);
            tick();
            check("thru_valid", 64'(o_valid), 64'd1);
            check("thru_alu", 64'(o_alu_result), 64'h100 + 64'(i));
            check("thru_m2r", 64'(o_mem_to_reg), 64'd1);
        end
        i_valid = 1'b0;
        tick();
        check("thru_drain", 64'(o_valid), 64'd0);

        // Back-pressure: offer A, B, C with WB stalled.
        i_ready = 1'b0;
        offer(32'hA, 3'b100, 5'd1, 1'b0);
        #1 check("bp_ready_a", 64'(o_ready), 64'd1);
        tick();
        offer(32'hB, 3'b100, 5'd2, 1'b0);
        #1 check("bp_ready_b", 64'(o_ready), SKID ? 64'd1 : 64'd0);
        tick();
        offer(32'hC, 3'b100, 5'd3, 1'b0);
        #1 check("bp_ready_c", 64'(o_ready), 64'd0);
        tick();
        check("bp_head_a", 64'(o_alu_result), 64'hA);
        check("bp_valid_a", 64'(o_valid), 64'd1);
        i_valid = 1'b0;
        i_ready = 1'b1;
        tick();
        check("bp_valid_2", 64'(o_valid), SKID ? 64'd1 : 64'd0);
        if (SKID) check("bp_head_b", 64'(o_alu_result), 64'hB);
        tick();
        check("bp_empty", 64'(o_valid), 64'd0);

        // Fill the stage, then flush with a concurrent push.
        i_ready = 1'b0;
        offer(32'h11, 3'b100, 5'd3, 1'b0);
        tick();
        offer(32'h22, 3'b100, 5'd3, 1'b0);
        tick();
        offer(32'h33, 3'b100, 5'd3, 1'b0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_regwr", 64'(o_reg_write), 64'd0);
        #1 check("fl_ready", 64'(o_ready), 64'd1);
        i_ready = 1'b1;
        tick();
        check("fl_no_push", 64'(o_valid), 64'd0);

        // Write to register 0 is suppressed but the index is still shown.
        i_ready = 1'b0;
        offer(32'h77, 3'b100, 5'd0, 1'b0);
        tick();
        i_valid = 1'b0;
        check("r0_valid", 64'(o_valid), 64'd1);
        check("r0_regwr", 64'(o_reg_write), 64'd0);
        check("r0_wreg", 64'(o_write_register), 64'd0);
        i_ready = 1'b1;
        tick();
        check("r0_pop", 64'(o_valid), 64'd0);

        // HALT entry: visible at head, sticky after pop, survives flush.
        i_ready = 1'b0;
        offer(32'h99, 3'b000, 5'd0, 1'b1);
        tick();
        i_valid = 1'b0;
        i_halt_detected = 1'b0;
        check("h_detect", 64'(o_halt_detected), 64'd1);
        check("h_not_yet", 64'(o_halted), 64'd0);
        i_ready = 1'b1;
        tick();
        check("h_halted", 64'(o_halted), 64'd1);
        check("h_detect_off", 64'(o_halt_detected), 64'd0);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        check("h_after_flush", 64'(o_halted), 64'd1);

        // Freeze with an entry held while MEM and WB both request.
        i_ready = 1'b0;
        offer(32'h5A, 3'b100, 5'd7, 1'b0);
        tick();
        i_enable_pipe = 1'b0;
        offer(32'h6B, 3'b100, 5'd8, 1'b0);
        i_ready = 1'b1;
        #1 check("fz_ready", 64'(o_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fz_valid", 64'(o_valid), 64'd1);
            check("fz_alu", 64'(o_alu_result), 64'h5A);
            check("fz_wreg", 64'(o_write_register), 64'd7);
            check("fz_halted", 64'(o_halted), 64'd1);
        end
        i_enable_pipe = 1'b1;
        i_valid = 1'b0;
        tick();
        check("fz_resume_pop", 64'(o_valid), 64'd0);
        offer(32'h7C, 3'b100, 5'd4, 1'b0);
        tick();
        check("fz_resume_push", 64'(o_alu_result), 64'h7C);

        // Reset mid-operation with an entry held clears entries and halt.
        i_ready = 1'b0;
        tick();
        check("mr_held", 64'(o_valid), 64'd1);
        i_reset = 1'b1;
        i_flush = 1'b1;
        tick();
        i_reset = 1'b0;
        i_flush = 1'b0;
        i_valid = 1'b0;
        check("mr_valid", 64'(o_valid), 64'd0);
        check("mr_halted", 64'(o_halted), 64'd0);
        check("mr_alu", 64'(o_alu_result), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
